// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: phase codes and datapath widths.
package fetch_pkg;

    localparam int ADDR_W = 5;
    localparam int INST_W = 32;

    typedef enum logic [1:0] {
        PH_PC2MAR  = 2'b00,
        PH_MEMRD   = 2'b01,
        PH_MEM2MDR = 2'b10,
        PH_MDR2IR  = 2'b11
    } phase_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Phase decoder for the fetch stage: one-hot phase decode plus single-shot entry enables,
// so each register action fires once per phase regardless of how long the phase is held.
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  phase_t phase,
    output logic   sig1_en,
    output logic   sig2_active,
    output logic   sig3_en,
    output logic   sig4_en
);

    phase_t prev_phase;
    logic   entry;
    logic   sig1;
    logic   sig2;
    logic   sig3;
    logic   sig4;

    // Reset to the last phase of a round so a fresh 00 after reset counts as an entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_phase <= PH_MDR2IR;
        end else begin
            prev_phase <= phase;
        end
    end

    assign entry = (phase != prev_phase);

    always_comb begin
        sig1 = (phase == PH_PC2MAR);
        sig2 = (phase == PH_MEMRD);
        sig3 = (phase == PH_MEM2MDR);
        sig4 = (phase == PH_MDR2IR);
    end

    assign sig1_en     = sig1 & entry;
    assign sig2_active = sig2;
    assign sig3_en     = sig3 & entry;
    assign sig4_en     = sig4 & entry;

endmodule

// File: rtl/fetch_stage_auto.sv
// Instruction fetch stage: PC, MAR, MDR and IR sequenced by an external 2-bit phase code,
// driving a synchronous program memory with one-clock read latency.
module fetch_stage_auto
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ControlSig_2,
    input  logic              ControlSig_1,
    input  logic              PC_write,
    input  logic [ADDR_W-1:0] PC_addressin,
    input  logic              PM_wr,
    input  logic [INST_W-1:0] PM_inst_inp,
    input  logic [INST_W-1:0] pm_rdata,
    output logic [ADDR_W-1:0] pm_addr,
    output logic              pm_rd,
    output logic              pm_we,
    output logic [INST_W-1:0] pm_wdata,
    output logic [INST_W-1:0] Fetch_out
);

    phase_t            phase;
    logic              sig1_en;
    logic              sig2_active;
    logic              sig3_en;
    logic              sig4_en;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [INST_W-1:0] mdr;
    logic [INST_W-1:0] ir;

    assign phase = phase_t'({ControlSig_2, ControlSig_1});

    fetch_ctrl u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .phase       (phase),
        .sig1_en     (sig1_en),
        .sig2_active (sig2_active),
        .sig3_en     (sig3_en),
        .sig4_en     (sig4_en)
    );

    // An explicit PC load wins over the end-of-round increment on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc  <= '0;
            mar <= '0;
            mdr <= '0;
            ir  <= '0;
        end else begin
            if (sig1_en) begin
                mar <= pc;
            end
            if (sig3_en) begin
                mdr <= pm_rdata;
            end
            if (sig4_en) begin
                ir <= mdr;
            end
            if (PC_write) begin
                pc <= PC_addressin;
            end else if (sig4_en) begin
                pc <= pc + ADDR_W'(1);
            end
        end
    end

    assign pm_addr   = mar;
    assign pm_rd     = sig2_active & ~PM_wr;
    assign pm_we     = PM_wr;
    assign pm_wdata  = PM_inst_inp;
    assign Fetch_out = ir;

endmodule

// File: tb/tb_fetch_stage_auto.sv
// Self-checking bench for fetch_stage_auto: directed rounds plus a random phase walk
// compared against a behavioural model of the fetch rules and program memory.
module tb_fetch_stage_auto;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs2;
    logic        cs1;
    logic        pc_write;
    logic [4:0]  pc_addressin;
    logic        pm_wr;
    logic [31:0] pm_inst_inp;
    logic [31:0] pm_rdata = 32'h0;
    logic [4:0]  pm_addr;
    logic        pm_rd;
    logic        pm_we;
    logic [31:0] pm_wdata;
    logic [31:0] fetch_out;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int          m_pc;
    int          m_mar;
    int          m_prev;
    logic [31:0] m_mdr;
    logic [31:0] m_ir;
    logic [31:0] m_rdata;
    logic [31:0] m_mem [32];

    logic [31:0] mem [32];
    logic        mem_ready = 1'b0;

    fetch_stage_auto dut (
        .clk          (clk),
        .reset        (reset),
        .ControlSig_2 (cs2),
        .ControlSig_1 (cs1),
        .PC_write     (pc_write),
        .PC_addressin (pc_addressin),
        .PM_wr        (pm_wr),
        .PM_inst_inp  (pm_inst_inp),
        .pm_rdata     (pm_rdata),
        .pm_addr      (pm_addr),
        .pm_rd        (pm_rd),
        .pm_we        (pm_we),
        .pm_wdata     (pm_wdata),
        .Fetch_out    (fetch_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h8C01_0000;
            1:       return 32'h8C02_0001;
            2:       return 32'h0041_1820;
            3:       return 32'h8C03_0002;
            4:       return 32'h2044_0006;
            31:      return 32'h3131_3131;
            default: return 32'hC0DE_0000 | 32'(i);
        endcase
    endfunction

    // Synchronous program memory, one clock read latency, preloaded on its first edge
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (pm_we) begin
            mem[pm_addr] <= pm_wdata;
        end
        pm_rdata <= mem[pm_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = 0;
        m_mar  = 0;
        m_mdr  = 32'h0;
        m_ir   = 32'h0;
        m_prev = 3;
    endtask

    // Drive one clock of stimulus, check combinational outputs, advance the model, check state
    task automatic applyStimulus(input int ph, input logic pcw, input logic [4:0] pcin,
                                 input logic wr, input logic [31:0] data);
        logic [31:0] next_rdata;
        int          old_pc;
        logic [31:0] old_mdr;
        {cs2, cs1}   = ph[1:0];
        pc_write     = pcw;
        pc_addressin = pcin;
        pm_wr        = wr;
        pm_inst_inp  = data;
        #1;
        checkOutput("pm_rd", 32'(pm_rd), 32'((ph == 1) && !wr));
        checkOutput("pm_we", 32'(pm_we), 32'(wr));
        checkOutput("pm_wdata", pm_wdata, data);
        checkOutput("pm_addr", 32'(pm_addr), 32'(m_mar));

        next_rdata = m_mem[m_mar];
        if (wr) m_mem[m_mar] = data;
        old_pc  = m_pc;
        old_mdr = m_mdr;
        if (ph != m_prev) begin
            case (ph)
                0: m_mar = old_pc;
                2: m_mdr = m_rdata;
                3: begin
                    m_ir = old_mdr;
                    m_pc = (old_pc + 1) % 32;
                end
                default: ;
            endcase
        end
        if (pcw) m_pc = int'(pcin);
        m_prev  = ph;
        m_rdata = next_rdata;

        @(posedge clk);
        #1;
        checkOutput("fetch_out", fetch_out, m_ir);
        checkOutput("pm_addr_q", 32'(pm_addr), 32'(m_mar));
    endtask

    // One nominal round; optionally load the PC on the sig4 entry clock
    task automatic run_round(input int n, input logic load, input logic [4:0] addr);
        for (int ph = 0; ph < 4; ph++) begin
            for (int k = 0; k < n; k++) begin
                applyStimulus(ph, (ph == 3 && k == 0) ? load : 1'b0, addr, 1'b0, 32'h0);
            end
        end
    endtask

    logic [31:0] expect_words [5];

    initial begin
        expect_words[0] = 32'h8C01_0000;
        expect_words[1] = 32'h8C02_0001;
        expect_words[2] = 32'h0041_1820;
        expect_words[3] = 32'h8C03_0002;
        expect_words[4] = 32'h2044_0006;
        for (int i = 0; i < 32; i++) m_mem[i] = init_word(i);

        reset = 1'b1;
        {cs2, cs1} = 2'b00;
        pc_write = 1'b0;
        pc_addressin = 5'd0;
        pm_wr = 1'b0;
        pm_inst_inp = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        m_rdata = init_word(0);

        checkOutput("reset_fetch_out", fetch_out, 32'h0);
        checkOutput("reset_pm_addr", 32'(pm_addr), 32'h0);
        checkOutput("reset_pm_rd", 32'(pm_rd), 32'h0);
        applyStimulus(0, 1'b0, 5'd0, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 5'd0, 1'b0, 32'h0);
        checkOutput("hold00_pm_addr", 32'(pm_addr), 32'h0);
        checkOutput("hold00_fetch_out", fetch_out, 32'h0);

        for (int r = 0; r < 5; r++) begin
            run_round(2, 1'b0, 5'd0);
            checkOutput("round_fetch", fetch_out, expect_words[r]);
        end
        applyStimulus(0, 1'b0, 5'd0, 1'b0, 32'h0);
        checkOutput("pc_after_5", 32'(pm_addr), 32'd5);

        run_round(2, 1'b1, 5'd31);
        run_round(2, 1'b0, 5'd0);
        checkOutput("fetch_word31", fetch_out, 32'h3131_3131);
        run_round(2, 1'b0, 5'd0);
        checkOutput("fetch_wrap0", fetch_out, 32'h8C01_0000);

        run_round(2, 1'b1, 5'd7);
        applyStimulus(0, 1'b0, 5'd0, 1'b0, 32'h0);
        checkOutput("pcload_prio_addr", 32'(pm_addr), 32'd7);
        run_round(2, 1'b0, 5'd0);
        checkOutput("pcload_prio_fetch", fetch_out, init_word(7));

        run_round(2, 1'b1, 5'd2);
        run_round(2, 1'b0, 5'd0);
        checkOutput("fetch_word2", fetch_out, 32'h0041_1820);
        applyStimulus(0, 1'b0, 5'd0, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 5'd0, 1'b0, 32'h0);
        applyStimulus(2, 1'b0, 5'd0, 1'b0, 32'h0);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_fetch", fetch_out, 32'h0);
        checkOutput("async_reset_addr", 32'(pm_addr), 32'h0);
        #1;
        reset = 1'b0;
        model_reset();
        applyStimulus(2, 1'b0, 5'd0, 1'b0, 32'h0);
        run_round(2, 1'b0, 5'd0);
        checkOutput("post_reset_fetch", fetch_out, 32'h8C01_0000);

        run_round(2, 1'b1, 5'd2);
        applyStimulus(0, 1'b0, 5'd0, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 5'd0, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 5'd0, 1'b1, 32'hDEAD_BEEF);
        checkOutput("wr_pm_we", 32'(pm_we), 32'h1);
        checkOutput("wr_pm_rd", 32'(pm_rd), 32'h0);
        checkOutput("wr_pm_addr", 32'(pm_addr), 32'd2);
        checkOutput("wr_pm_wdata", pm_wdata, 32'hDEAD_BEEF);
        applyStimulus(1, 1'b0, 5'd0, 1'b0, 32'h0);
        applyStimulus(2, 1'b0, 5'd0, 1'b0, 32'h0);
        applyStimulus(2, 1'b0, 5'd0, 1'b0, 32'h0);
        applyStimulus(3, 1'b0, 5'd0, 1'b0, 32'h0);
        applyStimulus(3, 1'b0, 5'd0, 1'b0, 32'h0);
        checkOutput("wr_fetch_back", fetch_out, 32'hDEAD_BEEF);

        for (int s = 0; s < 300; s++) begin
            applyStimulus(int'($urandom_range(0, 3)),
                          ($urandom_range(0, 15) == 0),
                          5'($urandom_range(0, 31)),
                          ($urandom_range(0, 7) == 0),
                          $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
